// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared types and defaults for the elastic pipeline stage
package pipe_stage_pkg;

    // Occupancy of the two-entry skid stage
    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // no entries
        BUSY  = 2'd1,  // one entry, held in main
        FULL  = 2'd2   // two entries: main is older, skid is younger
    } pipe_state_t;

    localparam int DEFAULT_PIPE_WIDTH = 71;

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - load-enabled payload register with asynchronous active-low clear
module pipe_data_reg #(
    parameter int WIDTH = 71
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d only when load is asserted; hold otherwise, stale contents included
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry valid/ready skid stage with flush; optional stall counter via PIPE_STALL_COUNT_EN
module pipe_skid_stage
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_PIPE_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             softReset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData
`ifdef PIPE_STALL_COUNT_EN
    ,
    output logic [CNT_W-1:0] stallCount
`endif
);

    // Reject degenerate configurations at elaboration
    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_skid_stage: WIDTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_skid_stage: CNT_W must be at least 1");
    end

    pipe_state_t      state;
    pipe_state_t      state_next;
    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             skid_load;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = inValid & inReady;
    assign out_fire = outValid & outReady;

    // State register; the async clear empties the stage without a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next occupancy; a flush wins over any handshake in the same cycle
    always_comb begin
        state_next = state;
        if (softReset) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) state_next = BUSY;
                end
                BUSY: begin
                    if (in_fire && !out_fire) begin
                        state_next = FULL;
                    end else if (!in_fire && out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) state_next = BUSY;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Handshake flags come from the state register alone, so outReady never reaches inReady
    always_comb begin
        outValid       = (state != EMPTY);
        inReady        = (state != FULL);
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!softReset) begin
            unique case (state)
                EMPTY: begin
                    main_load = in_fire;
                end
                BUSY: begin
                    main_load = in_fire & out_fire;
                    skid_load = in_fire & ~out_fire;
                end
                FULL: begin
                    main_load      = out_fire;
                    main_from_skid = 1'b1;
                end
                default: begin
                    main_load = 1'b0;
                end
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : inData;

    pipe_data_reg #(
        .WIDTH(WIDTH)
    ) u_main_reg (
        .clk    (clk),
        .clear_n(reset),
        .load   (main_load),
        .d      (main_d),
        .q      (main_q)
    );

    pipe_data_reg #(
        .WIDTH(WIDTH)
    ) u_skid_reg (
        .clk    (clk),
        .clear_n(reset),
        .load   (skid_load),
        .d      (inData),
        .q      (skid_q)
    );

    assign outData = main_q;

`ifdef PIPE_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_q;

    // Count cycles where a beat waits on downstream; saturate instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (softReset) begin
            stall_q <= '0;
        end else if (outValid && !outReady && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stallCount = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - table-driven self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

    localparam int W  = 71;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          softReset;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  inData;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  outData;
`ifdef PIPE_STALL_COUNT_EN
    logic [CW-1:0] stallCount;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .softReset (softReset),
        .inValid   (inValid),
        .inReady   (inReady),
        .inData    (inData),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData)
`ifdef PIPE_STALL_COUNT_EN
        ,
        .stallCount(stallCount)
`endif
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         sr;
        logic         ev;
        logic         er;
        logic [W-1:0] ed;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [W-1:0] id, input logic ordy, input logic sr,
                       input logic ev, input logic er, input logic [W-1:0] ed);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.sr = sr;
        v.ev = ev; v.er = er; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic check_ports(input string tag, input logic ev, input logic er, input logic [W-1:0] ed);
        check({tag, " outValid"}, W'(outValid), W'(ev));
        check({tag, " inReady"},  W'(inReady),  W'(er));
        check({tag, " outData"},  outData,      ed);
    endtask

    task automatic step(input vec_t v, input string tag);
        inValid   = v.iv;
        inData    = v.id;
        outReady  = v.ordy;
        softReset = v.sr;
        @(posedge clk);
        #1;
        check_ports(tag, v.ev, v.er, v.ed);
    endtask

    initial begin
        logic [W-1:0] wide;
        vec_t         v;
        wide = {1'b1, 66'h0, 4'h1};

        // ---- vector table: {inValid, inData, outReady, softReset} -> {outValid, inReady, outData}
        // idle after reset
        add(0, 71'h0,  0, 0,  0, 1, 71'h0);
        add(0, 71'h0,  1, 0,  0, 1, 71'h0);
        // streaming with outReady high: each beat shows up one cycle later
        add(1, 71'h1,  1, 0,  1, 1, 71'h1);
        add(1, 71'h2,  1, 0,  1, 1, 71'h2);
        add(1, 71'h3,  1, 0,  1, 1, 71'h3);
        add(1, wide,   1, 0,  1, 1, wide);
        add(0, 71'h0,  1, 0,  0, 1, wide);
        // stall / skid: A then B with downstream stalled
        add(1, 71'hA,  0, 0,  1, 1, 71'hA);
        add(1, 71'hB,  0, 0,  1, 0, 71'hA);
        add(1, 71'hC,  0, 0,  1, 0, 71'hA);
        add(1, 71'hC,  1, 0,  1, 1, 71'hB);
        add(0, 71'h0,  1, 0,  0, 1, 71'hB);
        // flush from FULL holding 5/6 with a beat offered and downstream ready
        add(1, 71'h5,  0, 0,  1, 1, 71'h5);
        add(1, 71'h6,  0, 0,  1, 0, 71'h5);
        add(1, 71'h7,  1, 1,  0, 1, 71'h5);
        add(0, 71'h0,  1, 0,  0, 1, 71'h5);
        // flush while empty voids the offered beat
        add(1, 71'h8,  1, 1,  0, 1, 71'h5);
        add(0, 71'h0,  1, 0,  0, 1, 71'h5);
        // flush from BUSY
        add(1, 71'h21, 0, 0,  1, 1, 71'h21);
        add(0, 71'h0,  0, 1,  0, 1, 71'h21);
        // into BUSY for the async reset sequence
        add(1, 71'h9,  1, 0,  1, 1, 71'h9);

        // ---- reset held for 3 cycles
        reset     = 1'b0;
        softReset = 1'b0;
        inValid   = 1'b0;
        inData    = '0;
        outReady  = 1'b0;
        #1;
        check_ports("reset t0", 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_ports($sformatf("reset c%0d", i), 1'b0, 1'b1, '0);
        end
`ifdef PIPE_STALL_COUNT_EN
        check("reset stallCount", W'(stallCount), W'(0));
`endif
        reset = 1'b1;

        // ---- apply the table
        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // ---- async reset mid-transfer (stage holds 71'h9 in BUSY)
        inValid  = 1'b1;
        inData   = 71'h77;
        outReady = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check_ports("async mid", 1'b0, 1'b1, '0);
        @(posedge clk);
        #1;
        check_ports("async held", 1'b0, 1'b1, '0);
        reset = 1'b1;
        // first edge after release already accepts a beat
        v.iv = 1'b1; v.id = 71'h55; v.ordy = 1'b0; v.sr = 1'b0;
        v.ev = 1'b1; v.er = 1'b1; v.ed = 71'h55;
        step(v, "release first");

        // ---- long stall holding one beat
        v.iv = 1'b0; v.id = 71'h0; v.ordy = 1'b0; v.sr = 1'b0;
        v.ev = 1'b1; v.er = 1'b1; v.ed = 71'h55;
        for (int i = 1; i <= 20; i++) begin
            step(v, $sformatf("stall%0d", i));
`ifdef PIPE_STALL_COUNT_EN
            if (i == 3 || i == 14 || i == 15 || i == 20) begin
                check($sformatf("stallCount c%0d", i), W'(stallCount),
                      (i == 3) ? W'(3) : ((i == 14) ? W'(14) : W'(15)));
            end
`endif
        end
        v.sr = 1'b1; v.ev = 1'b0;
        step(v, "stall flush");
`ifdef PIPE_STALL_COUNT_EN
        check("stallCount flush", W'(stallCount), W'(0));
`endif
        softReset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
